fact_accel_host: RTL and testbench
==================================

Name: fact_accel_host

Overview:
- Bus-initiator counterpart of the memory-mapped factorial accelerator; drives its cs/readmem/writemem/address/data bus and consumes its memDataReady and interrupt.
- Takes one request {n, irq mode}, then runs this sequence on the bus: program N, program INT_EN, START, wait for done (poll or interrupt), read FN bytes 0..3, clear DONE.
- Returns the 32-bit result on a valid/ready response port. Sits between a processor-side command source and the accelerator in system testbenches and SoC top.

Parameters:
- DATA_WIDTH, 8, accelerator bus data width.
- ADDR_WIDTH, 12, accelerator bus address width.
- TIMEOUT_CYCLES, 64, max cycles to wait for memDataReady per transaction before error.
- POLL_GAP, 4, idle cycles between consecutive DONE polls.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_n  in  8  factorial operand
- req_use_irq  in  1  1 = wait on interrupt, 0 = poll DONE register
- resp_valid  out  1  result/error available
- resp_ready  in  1  consumer accepts response
- resp_fn  out  32  assembled result {byte4,byte3,byte2,byte1}
- resp_err  out  1  transaction timeout occurred
- cs  out  1  accelerator chip select
- readmem  out  1  read strobe
- writemem  out  1  write strobe
- address  out  ADDR_WIDTH  register address
- wdata  out  DATA_WIDTH  write data to accelerator dataIn
- rdata  in  DATA_WIDTH  accelerator dataOut (Z when not read)
- memDataReady  in  1  accelerator ready pulse (asynchronous to clk)
- interrupt  in  1  accelerator done&int_en level

Behaviour:
- Register map: N=0, FN0..FN3=1..4, START=5, INT_EN=6, DONE=7 (read bit0; any write clears).
- Reset (rst=0, immediate): cs/readmem/writemem=0, address=0, wdata=0, resp_valid=0, resp_err=0, resp_fn=0, state IDLE. A reset in mid-transaction drops the strobes asynchronously, with no completion.
- memDataReady passes through a 2-flop synchronizer. `mdr_s` is the synchronized level.
- Transaction rule:
  - cs, strobe, address and wdata are asserted together and held stable until mdr_s=1 is sampled.
  - Strobes then deassert on the next edge.
  - At least one idle cycle (cs=0) is inserted between transactions.
  - Read data is captured from rdata on the clk edge where mdr_s is first seen high.
- START exception: the START write (addr 5, wdata=1) is a single-cycle strobe and does not wait for memDataReady. This avoids repeated start.
- Timeout: a per-transaction counter runs while waiting. Reaching TIMEOUT_CYCLES sets resp_err=1, deasserts strobes, and jumps to RESP with resp_fn=0.
- FSM states and transitions:
  - IDLE: on req_valid && req_ready, latch n and use_irq, go to WR_N.
  - WR_N: write addr 0 = n, then go to WR_IE.
  - WR_IE: write addr 6 = {0, use_irq}, then go to START.
  - START: single-cycle write as above, then go to WAIT.
  - WAIT, irq mode: wait for interrupt=1, with no timeout (interrupt is a level).
  - WAIT, poll mode: read addr 7; if bit0=0, idle POLL_GAP cycles and re-poll; if bit0=1, go to RD.
  - RD: read addr 1,2,3,4 into fn[7:0],[15:8],[23:16],[31:24].
  - CLR: write addr 7 = 0.
  - RESP: resp_valid=1; hold resp_fn and resp_err stable until resp_ready; return to IDLE the cycle after the handshake. resp_err clears on that return.
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake.
- wdata=0 whenever writemem=0; address holds its last value when cs=0.

Decomposition:
- Package fact_accel_pkg: register address constants, state enumeration, FN byte count (4).
- Sub-module mm_bus_master performs one read/write transaction. It owns the synchronizer, the strobes, the timeout counter and the single-cycle mode. Its interface is go/is_write/single/addr/wdata in and done/rdata_q/timeout out.
- The top level holds the sequencing FSM and the result register.

Test Plan:
- n=5, poll mode: bus shows writes 0←5, 6←0, 5←1 (1 cycle), DONE polls, reads 1..4, write 7; response resp_fn=120 (0x00000078), resp_err=0.
- n=10, irq mode: 6←1 written; no DONE polls before interrupt; resp_fn=0x00375F00 (3628800).
- n=0 and n=12: resp_fn=1 and resp_fn=0x1C8CFC00 respectively.
- memDataReady tied low: strobes drop after TIMEOUT_CYCLES on WR_N; resp_valid=1, resp_err=1, resp_fn=0; next request then works normally.
- rst pulsed low during the FN2 read: cs/readmem go 0 within the same time step; req_ready=1 after release; a subsequent n=4 returns 24.
- resp_ready held low 10 cycles: resp_valid and resp_fn stable; req_ready stays 0; a second req_valid is not accepted until after the handshake.

Source files
------------

// File: rtl/fact_accel_pkg.sv
// -----------------------------------------------------------------------------
// fact_accel_pkg
// Shared constants for the factorial-accelerator host.
//   - Accelerator register map (byte addresses on the accelerator bus)
//   - Host sequencing FSM state codes (plain localparams for legacy tools)
//   - Number of result bytes read back from the FN registers
// -----------------------------------------------------------------------------
package fact_accel_pkg;

    // Accelerator register map
    localparam int unsigned REG_N      = 0;
    localparam int unsigned REG_FN0    = 1;   // FN1..FN3 follow at 2..4
    localparam int unsigned REG_START  = 5;
    localparam int unsigned REG_INT_EN = 6;
    localparam int unsigned REG_DONE   = 7;   // bit0 = done, any write clears

    localparam int unsigned FN_BYTES   = 4;

    // Host sequencing states
    localparam int unsigned STATE_W = 4;
    localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] S_WR_N  = 4'd1;
    localparam logic [STATE_W-1:0] S_WR_IE = 4'd2;
    localparam logic [STATE_W-1:0] S_START = 4'd3;
    localparam logic [STATE_W-1:0] S_WAIT  = 4'd4;
    localparam logic [STATE_W-1:0] S_GAP   = 4'd5;
    localparam logic [STATE_W-1:0] S_RD    = 4'd6;
    localparam logic [STATE_W-1:0] S_CLR   = 4'd7;
    localparam logic [STATE_W-1:0] S_RESP  = 4'd8;

endpackage

// File: rtl/fact_accel_host_if.sv
// -----------------------------------------------------------------------------
// fact_accel_host_if
// Memory-mapped bus between the host (master) and the factorial accelerator
// (slave).
//   cs, readmem, writemem : chip select and read/write strobes (master)
//   address, wdata        : register address and write data    (master)
//   rdata                 : read data, Z when not being read    (slave)
//   memDataReady          : access-complete pulse, async to clk (slave)
//   interrupt             : done & int_en level                 (slave)
// -----------------------------------------------------------------------------
interface fact_accel_host_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  cs;
    logic                  readmem;
    logic                  writemem;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  memDataReady;
    logic                  interrupt;

    modport master (
        output cs, readmem, writemem, address, wdata,
        input  rdata, memDataReady, interrupt
    );

    modport slave (
        input  cs, readmem, writemem, address, wdata,
        output rdata, memDataReady, interrupt
    );
endinterface

// File: rtl/fact_accel_host_mm_bus_master.sv
// -----------------------------------------------------------------------------
// mm_bus_master
// Performs one read or write transaction on the accelerator bus per go pulse.
//   clk, rst           : clock, asynchronous active-low reset
//   go                 : start a transaction (ignored while one is in flight)
//   is_write, single   : write vs read; single = one-cycle strobe, no handshake
//   addr, wdata        : transaction address / write data
//   done               : one-cycle pulse, transaction completed
//   rdata_q            : read data captured when memDataReady was seen
//   timeout            : one-cycle pulse, memDataReady never arrived
//   bus                : accelerator bus (master side)
// -----------------------------------------------------------------------------
module mm_bus_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  is_write,
    input  logic                  single,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata_q,
    output logic                  timeout,
    fact_accel_host_if.master     bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             mdr_meta;
    logic             mdr_s;
    logic             busy;
    logic             single_q;
    logic             armed;
    logic [CNT_W-1:0] wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two sync stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdr_meta <= 1'b0;
            mdr_s    <= 1'b0;
        end else begin
            mdr_meta <= bus.memDataReady;
            mdr_s    <= mdr_meta;
        end
    end

    // The synchronizer lags the accelerator by two cycles, so the ready level
    // of the previous transaction can still be visible when the next one
    // starts. A transaction only completes after it has seen mdr_s low once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cs       <= 1'b0;
            bus.readmem  <= 1'b0;
            bus.writemem <= 1'b0;
            bus.address  <= '0;
            bus.wdata    <= '0;
            busy         <= 1'b0;
            single_q     <= 1'b0;
            armed        <= 1'b0;
            wait_cnt     <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (!busy) begin
                if (go) begin
                    bus.cs       <= 1'b1;
                    bus.readmem  <= !is_write;
                    bus.writemem <= is_write;
                    bus.address  <= addr;
                    bus.wdata    <= is_write ? wdata : '0;
                    busy         <= 1'b1;
                    single_q     <= single;
                    armed        <= 1'b0;
                    wait_cnt     <= '0;
                end
            end else if (single_q || (armed && mdr_s) || wait_cnt == CNT_LAST) begin
                bus.cs       <= 1'b0;
                bus.readmem  <= 1'b0;
                bus.writemem <= 1'b0;
                bus.wdata    <= '0;
                busy         <= 1'b0;
                if (single_q || (armed && mdr_s)) begin
                    done <= 1'b1;
                    if (bus.readmem) rdata_q <= bus.rdata;
                end else begin
                    timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
                if (!mdr_s) armed <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fact_accel_host.sv
// -----------------------------------------------------------------------------
// fact_accel_host
// Bus initiator for the memory-mapped factorial accelerator. Accepts one
// request {n, irq mode}, programs N and INT_EN, pulses START, waits for done
// (DONE polling or interrupt), reads FN0..FN3, clears DONE and returns the
// 32-bit result.
//   clk, rst                          : clock, asynchronous active-low reset
//   req_valid/req_ready/req_n/req_use_irq : request handshake
//   resp_valid/resp_ready/resp_fn/resp_err: response handshake
//   bus                               : accelerator bus (master side)
// -----------------------------------------------------------------------------
module fact_accel_host
    import fact_accel_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int POLL_GAP       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_n,
    input  logic              req_use_irq,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_fn,
    output logic              resp_err,
    fact_accel_host_if.master bus
);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

    logic [STATE_W-1:0]    state;
    logic [7:0]            n_q;
    logic                  irq_q;
    logic [1:0]            byte_idx;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  pending;   // current state's transaction issued

    logic                  go;
    logic                  is_write;
    logic                  single;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata_cmd;
    logic                  done;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] rdata_q;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        go        = 1'b0;
        is_write  = 1'b0;
        single    = 1'b0;
        addr      = '0;
        wdata_cmd = '0;
        case (state)
            S_WR_N: begin
                go        = !pending;
                is_write  = 1'b1;
                addr      = ADDR_WIDTH'(REG_N);
                wdata_cmd = DATA_WIDTH'(n_q);
            end
            S_WR_IE: begin
                go        = !pending;
                is_write  = 1'b1;
                addr      = ADDR_WIDTH'(REG_INT_EN);
                wdata_cmd = DATA_WIDTH'(irq_q);
            end
            S_START: begin
                // One-cycle strobe: waiting for ready could restart the engine.
                go        = !pending;
                is_write  = 1'b1;
                single    = 1'b1;
                addr      = ADDR_WIDTH'(REG_START);
                wdata_cmd = DATA_WIDTH'(1);
            end
            S_WAIT: begin
                go   = !pending && !irq_q;
                addr = ADDR_WIDTH'(REG_DONE);
            end
            S_RD: begin
                go   = !pending;
                addr = ADDR_WIDTH'(REG_FN0 + 32'(byte_idx));
            end
            S_CLR: begin
                go       = !pending;
                is_write = 1'b1;
                addr     = ADDR_WIDTH'(REG_DONE);
            end
            default: ;
        endcase
    end

    mm_bus_master #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_master (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .is_write(is_write),
        .single  (single),
        .addr    (addr),
        .wdata   (wdata_cmd),
        .done    (done),
        .rdata_q (rdata_q),
        .timeout (timeout),
        .bus     (bus)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            n_q      <= '0;
            irq_q    <= 1'b0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            pending  <= 1'b0;
            resp_fn  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (go)   pending <= 1'b1;
            if (done) pending <= 1'b0;
            if (timeout) begin
                pending  <= 1'b0;
                resp_err <= 1'b1;
                resp_fn  <= '0;
                state    <= S_RESP;
            end else begin
                case (state)
                    S_IDLE: if (req_valid) begin
                        n_q     <= req_n;
                        irq_q   <= req_use_irq;
                        resp_fn <= '0;
                        state   <= S_WR_N;
                    end
                    S_WR_N:  if (done) state <= S_WR_IE;
                    S_WR_IE: if (done) state <= S_START;
                    S_START: if (done) state <= S_WAIT;
                    S_WAIT: begin
                        if (irq_q) begin
                            if (bus.interrupt) begin
                                byte_idx <= '0;
                                state    <= S_RD;
                            end
                        end else if (done) begin
                            if (rdata_q[0]) begin
                                byte_idx <= '0;
                                state    <= S_RD;
                            end else begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) state <= S_WAIT;
                        else gap_cnt <= gap_cnt + 1'b1;
                    end
                    S_RD: if (done) begin
                        resp_fn[{byte_idx, 3'b000} +: 8] <= rdata_q[7:0];
                        if (byte_idx == 2'(FN_BYTES - 1)) state <= S_CLR;
                        else byte_idx <= byte_idx + 1'b1;
                    end
                    S_CLR:  if (done) state <= S_RESP;
                    S_RESP: if (resp_ready) begin
                        resp_err <= 1'b0;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fact_accel_host.sv
// -----------------------------------------------------------------------------
// tb_fact_accel_host
// Drives fact_accel_host against a behavioural accelerator model and checks
// bus sequencing, results, timeout, async reset and response back-pressure.
// -----------------------------------------------------------------------------
module tb_fact_accel_host;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int TO = 64;
    localparam int PG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_n = '0;
    logic        req_use_irq = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_fn;
    logic        resp_err;

    int n_vec  = 0;
    int n_miss = 0;

    fact_accel_host_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fact_accel_host #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .POLL_GAP(PG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_n      (req_n),
        .req_use_irq(req_use_irq),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_fn    (resp_fn),
        .resp_err   (resp_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] f;
        f = 32'd1;
        for (int i = 2; i <= n; i++) f = f * 32'(i);
        return f;
    endfunction

    // ---------------- accelerator model ----------------
    logic [7:0]  m_n = '0;
    logic [7:0]  m_ie = '0;
    logic        m_done = 1'b0;
    logic [31:0] m_fn = '0;
    bit          m_busy = 1'b0;
    int          m_calc = 0;
    int          acc_cnt = 0;
    int          acc_lat = 1;
    logic        mdr_r = 1'b0;
    bit          tie_low = 1'b0;
    int          start_count = 0;
    logic [7:0]  rd_val;

    wire strobe = bus.cs && (bus.readmem || bus.writemem);

    assign bus.memDataReady = mdr_r && strobe && !tie_low;
    assign bus.interrupt    = m_done && m_ie[0];
    assign bus.rdata        = (bus.cs && bus.readmem) ? rd_val : 'z;

    always_comb begin
        rd_val = '0;
        case (int'(bus.address))
            0: rd_val = m_n;
            1: rd_val = m_fn[7:0];
            2: rd_val = m_fn[15:8];
            3: rd_val = m_fn[23:16];
            4: rd_val = m_fn[31:24];
            6: rd_val = m_ie;
            7: rd_val = {7'b0, m_done};
            default: rd_val = '0;
        endcase
    end

    always @(posedge clk) begin
        if (m_busy) begin
            if (m_calc == 0) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_fn   <= fact(int'(m_n));
            end else begin
                m_calc <= m_calc - 1;
            end
        end
        if (!strobe) begin
            acc_cnt <= 0;
            mdr_r   <= 1'b0;
            acc_lat <= int'($urandom_range(1, 4));
        end else begin
            if (acc_cnt == 0 && bus.writemem && int'(bus.address) == 5 && bus.wdata[0]) begin
                m_busy      <= 1'b1;
                m_done      <= 1'b0;
                m_calc      <= int'($urandom_range(3, 25));
                start_count <= start_count + 1;
            end
            acc_cnt <= acc_cnt + 1;
            if (acc_cnt + 1 == acc_lat && !tie_low) begin
                mdr_r <= 1'b1;
                if (bus.writemem) begin
                    case (int'(bus.address))
                        0: m_n  <= bus.wdata;
                        6: m_ie <= bus.wdata;
                        7: m_done <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        bit wr;
        int addr;
        int data;
        int len;
    } tx_t;

    tx_t txq[$];
    tx_t mon_cur;
    bit  cs_prev = 1'b0;
    int  stab_err = 0;
    int  wdata_err = 0;
    int  start_base = 0;

    always @(negedge clk) begin
        if (bus.cs && !cs_prev) begin
            mon_cur.wr   = bus.writemem;
            mon_cur.addr = int'(bus.address);
            mon_cur.data = int'(bus.wdata);
            mon_cur.len  = 1;
        end else if (bus.cs) begin
            mon_cur.len = mon_cur.len + 1;
            if (bus.writemem !== mon_cur.wr || bus.readmem !== !mon_cur.wr ||
                int'(bus.address) != mon_cur.addr || int'(bus.wdata) != mon_cur.data)
                stab_err++;
        end else if (cs_prev) begin
            txq.push_back(mon_cur);
        end
        if (bus.writemem !== 1'b1 && bus.wdata !== '0) wdata_err++;
        cs_prev = bus.cs;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input int n, input bit irq);
        bit acc;
        acc = 1'b0;
        txq.delete();
        start_base  = start_count;
        req_valid   = 1'b1;
        req_n       = 8'(n);
        req_use_irq = irq;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!acc) check("req_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid) ok = 1'b1;
        end
        if (!ok) check("resp_wait", 32'(ok), 32'd1);
    endtask

    task automatic finish_resp(input int hold);
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // Expected bus order: W0=n, W6=irq, W5=1 (1 cycle), R7 polls, R1..R4, W7=0
    task automatic check_seq(input int n, input bit irq);
        int  i;
        int  polls;
        bit  ok;
        polls = 0;
        ok = (txq.size() >= 8);
        if (ok) begin
            ok = txq[0].wr && txq[0].addr == 0 && txq[0].data == (n & 255) &&
                 txq[1].wr && txq[1].addr == 6 && txq[1].data == int'(irq) &&
                 txq[2].wr && txq[2].addr == 5 && txq[2].data == 1;
            check("start_len", 32'(txq[2].len), 32'd1);
            i = 3;
            while (i < txq.size() && !txq[i].wr && txq[i].addr == 7) begin
                polls++;
                i++;
            end
            if (i + 5 != txq.size()) ok = 1'b0;
            else begin
                for (int b = 0; b < 4; b++)
                    if (txq[i+b].wr || txq[i+b].addr != 1 + b) ok = 1'b0;
                if (!txq[i+4].wr || txq[i+4].addr != 7 || txq[i+4].data != 0) ok = 1'b0;
            end
        end
        check("bus_seq", 32'(ok), 32'd1);
        if (irq) check("no_polls_irq", 32'(polls), 32'd0);
        else     check("polled", 32'(polls > 0), 32'd1);
        check("start_once", 32'(start_count - start_base), 32'd1);
        check("strobe_stable", 32'(stab_err), 32'd0);
        check("wdata_idle_zero", 32'(wdata_err), 32'd0);
    endtask

    task automatic run_case(input int n, input bit irq, input int hold);
        bit ok;
        send_req(n, irq);
        wait_resp(ok);
        if (ok) begin
            check("resp_fn", resp_fn, fact(n));
            check("resp_err", 32'(resp_err), 32'd0);
            finish_resp(hold);
            check_seq(n, irq);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        bit found;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_cs", 32'(bus.cs), 32'd0);
        check("rst_readmem", 32'(bus.readmem), 32'd0);
        check("rst_writemem", 32'(bus.writemem), 32'd0);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_wdata", 32'(bus.wdata), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_fn", resp_fn, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // directed cases
        run_case(5, 1'b0, 0);
        check("fn5_const", resp_fn, 32'h0000_0078);
        run_case(10, 1'b1, 1);
        check("fn10_const", resp_fn, 32'h0037_5F00);
        run_case(0, 1'b0, 0);
        run_case(12, 1'b1, 2);
        check("fn12_const", resp_fn, 32'h1C8C_FC00);

        // memDataReady stuck low: timeout on the N write
        tie_low = 1'b1;
        send_req(3, 1'b0);
        wait_resp(ok);
        if (ok) begin
            check("to_err", 32'(resp_err), 32'd1);
            check("to_fn", resp_fn, 32'd0);
            finish_resp(0);
            check("to_err_clear", 32'(resp_err), 32'd0);
            check("to_tx_count", 32'(txq.size()), 32'd1);
            if (txq.size() > 0) begin
                check("to_tx_len", 32'(txq[0].len), 32'(TO));
                check("to_tx_addr", 32'(txq[0].addr), 32'd0);
            end
        end
        tie_low = 1'b0;
        run_case(6, 1'b1, 0);

        // async reset during the FN2 read
        send_req(7, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (bus.cs && bus.readmem && int'(bus.address) == 2) found = 1'b1;
        end
        check("fn2_reached", 32'(found), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_cs", 32'(bus.cs), 32'd0);
        check("mid_rst_readmem", 32'(bus.readmem), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        run_case(4, 1'b0, 0);
        check("fn4_const", resp_fn, 32'd24);

        // back-pressure: resp_ready low 10 cycles with a second request waiting
        send_req(6, 1'b0);
        wait_resp(ok);
        if (ok) begin
            req_valid   = 1'b1;
            req_n       = 8'd3;
            req_use_irq = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("hold_valid", 32'(resp_valid), 32'd1);
                check("hold_fn", resp_fn, fact(6));
                check("hold_req_ready", 32'(req_ready), 32'd0);
                check("hold_no_bus", 32'(bus.cs), 32'd0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            check("hs_resp_valid", 32'(resp_valid), 32'd0);
            check("hs_req_ready", 32'(req_ready), 32'd1);
            txq.delete();
            start_base = start_count;
            @(negedge clk);
            req_valid = 1'b0;
            wait_resp(ok);
            if (ok) begin
                check("b2b_fn", resp_fn, 32'd6);
                finish_resp(0);
                check_seq(3, 1'b1);
            end
        end else begin
            req_valid = 1'b0;
        end

        // randomized requests
        for (int k = 0; k < 8; k++) begin
            run_case(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
